// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_class_t;

    // Indexed {row,col}; E stands for '*' and F for '#'.
    localparam logic [3:0] LEGEND [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] legend(input logic [1:0] row, input logic [1:0] col);
        return LEGEND[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_frame_classify.sv
// Classifies one scan frame: no key, exactly one key (with its position), or several.
module keypad_frame_classify
    import keypad_pkg::*;
(
    input  logic [15:0] pressed,
    output logic [1:0]  frame_class,
    output logic [1:0]  row,
    output logic [1:0]  col
);

    logic [1:0] hits;
    logic [3:0] idx;

    // Hit count saturates at 2; only the single-key case needs the position.
    always_comb begin
        hits = '0;
        idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (pressed[i]) begin
                idx = 4'(i);
                if (hits != 2'd2) hits = hits + 2'd1;
            end
        end
        case (hits)
            2'd0:    frame_class = NONE;
            2'd1:    frame_class = SINGLE;
            default: frame_class = MULTI;
        endcase
        row = idx[1:0];
        col = idx[3:2];
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, frame-level debounce, hex code + strobe output.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic       key_down
);

    localparam int              VEC_W    = NUM_ROWS * NUM_COLS;
    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DS       = 4'(DEBOUNCE_SCANS);

    logic [DIV_W-1:0] div;
    logic [3:0]       rows_meta, rows_sync;
    logic [1:0]       col_idx;
    logic [VEC_W-1:0] pressed;
    logic             eval;
    logic             sample;

    assign sample = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_meta <= 4'b1111;
            rows_sync <= 4'b1111;
            div       <= '0;
            col_idx   <= '0;
            cols      <= 4'b1110;
            pressed   <= '0;
            eval      <= 1'b0;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
            div       <= sample ? '0 : div + 1'b1;
            eval      <= sample && (col_idx == 2'd3);
            // eval lands on div==0, so the clear never collides with a sample.
            if (eval) pressed <= '0;
            if (sample) begin
                pressed[{col_idx, 2'b00} +: 4] <= ~rows_sync;
                cols    <= {cols[2:0], cols[3]};
                col_idx <= col_idx + 2'd1;
            end
        end
    end

    logic [1:0] cls, f_row, f_col;

    keypad_frame_classify u_classify (
        .pressed     (pressed),
        .frame_class (cls),
        .row         (f_row),
        .col         (f_col)
    );

    state_t     state, state_n;
    logic [3:0] cand, cand_n;     // bit index {col,row} into the pressed vector
    logic [3:0] cnt, cnt_n;
    logic [3:0] code_n;
    logic       strobe_n, down_n, accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cand       <= '0;
            cnt        <= '0;
            key_code   <= '0;
            key_strobe <= 1'b0;
            key_down   <= 1'b0;
        end else begin
            state      <= state_n;
            cand       <= cand_n;
            cnt        <= cnt_n;
            key_code   <= code_n;
            key_strobe <= strobe_n;
            key_down   <= down_n;
        end
    end

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        code_n   = key_code;
        strobe_n = 1'b0;
        down_n   = key_down;
        accept   = 1'b0;
        if (eval) begin
            case (state)
                IDLE: begin
                    if (cls == SINGLE) begin
                        cand_n  = {f_col, f_row};
                        cnt_n   = 4'd1;
                        state_n = DEBOUNCE;
                        accept  = (cnt_n == DS);
                    end
                end
                DEBOUNCE: begin
                    if (cls == SINGLE && {f_col, f_row} == cand) begin
                        cnt_n  = cnt + 4'd1;
                        accept = (cnt_n == DS);
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    // Other keys are ignored while the accepted one stays down.
                    if (!pressed[cand]) begin
                        cnt_n   = 4'd1;
                        state_n = RELEASE;
                        if (cnt_n == DS) begin
                            state_n = IDLE;
                            down_n  = 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    if (!pressed[cand]) begin
                        cnt_n = cnt + 4'd1;
                        if (cnt_n == DS) begin
                            state_n = IDLE;
                            down_n  = 1'b0;
                        end
                    end else begin
                        state_n = HELD;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (accept) begin
                state_n  = HELD;
                strobe_n = 1'b1;
                down_n   = 1'b1;
                code_n   = legend(cand_n[1:0], cand_n[3:2]);
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-level scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
    // Legend packed as entry (row*4+col) at bits [entry*4 +: 4].
    localparam logic [63:0] LG = 64'hDF0E_C987_B654_A321;

    // Key bit index = col*4 + row
    localparam logic [15:0] K1 = 16'h0001;   // row0 col0
    localparam logic [15:0] K5 = 16'h0020;   // row1 col1
    localparam logic [15:0] K6 = 16'h0200;   // row1 col2
    localparam logic [15:0] K0 = 16'h0080;   // row3 col1

    typedef struct packed {
        logic       strobe;
        logic       down;
        logic [3:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rows, cols, key_code;
    logic       key_strobe, key_down;
    logic [15:0] keys = '0;

    int vecs = 0, errs = 0, cyc = 0, strobes = 0;
    exp_t q[$];

    logic       m_down;
    logic [3:0] m_key, m_code;
    int         m_streak, m_rel;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rows       (rows),
        .cols       (cols),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .key_down   (key_down)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            if (cols == ~(4'b0001 << c)) rows = ~keys[c*4 +: 4];
    end

    initial forever begin
        @(posedge clk);
        if (rst) cyc = 0;
        else     cyc++;
    end

    // Monitor: checks columns every cycle; pops one expectation per frame evaluation.
    initial begin
        exp_t cur, e;
        logic [3:0] one, ec;
        cur = '0;
        one = 4'b0001;
        forever begin
            @(negedge clk);
            if (rst || cyc == 0) cur = '0;
            if (!rst) begin
                ec = ~(one << ((cyc / SCAN_DIV) % 4));
                vecs++;
                if (cols !== ec) begin
                    errs++; $display("FAIL cols @%0d: got %b want %b", cyc, cols, ec);
                end
                e = cur;
                e.strobe = 1'b0;
                if (cyc >= FRAME + 1 && cyc % FRAME == 1) begin
                    vecs++;
                    if (q.size() == 0) begin
                        errs++; $display("FAIL sb_empty @%0d: got no entry want one", cyc);
                    end else begin
                        e = q.pop_front();
                        cur = e;
                        cur.strobe = 1'b0;
                    end
                end
                vecs++;
                if (key_strobe !== e.strobe) begin
                    errs++; $display("FAIL strobe @%0d: got %b want %b", cyc, key_strobe, e.strobe);
                end
                vecs++;
                if (key_down !== e.down) begin
                    errs++; $display("FAIL down @%0d: got %b want %b", cyc, key_down, e.down);
                end
                vecs++;
                if (key_code !== e.code) begin
                    errs++; $display("FAIL code @%0d: got %h want %h", cyc, key_code, e.code);
                end
                if (key_strobe === 1'b1) strobes++;
            end
        end
    end

    task automatic model_reset();
        m_down = 1'b0; m_key = '0; m_code = '0; m_streak = 0; m_rel = 0;
    endtask

    // Streak-counting model of one frame evaluation.
    task automatic model_frame(input logic [15:0] v);
        int n, idx, entry;
        exp_t e;
        n = 0; idx = 0;
        for (int i = 0; i < 16; i++) if (v[i]) begin n++; idx = i; end
        e.strobe = 1'b0;
        if (!m_down) begin
            if (n == 1 && m_streak == 0) begin
                m_key = 4'(idx); m_streak = 1;
            end else if (n == 1 && 4'(idx) == m_key) begin
                m_streak++;
            end else begin
                m_streak = 0;
            end
            if (m_streak == DS) begin
                entry    = int'(m_key[1:0]) * 4 + int'(m_key[3:2]);
                m_code   = LG[entry*4 +: 4];
                m_down   = 1'b1;
                e.strobe = 1'b1;
                m_streak = 0;
                m_rel    = 0;
            end
        end else begin
            if (!v[m_key]) m_rel++;
            else           m_rel = 0;
            if (m_rel == DS) begin m_down = 1'b0; m_rel = 0; end
        end
        e.down = m_down;
        e.code = m_code;
        q.push_back(e);
    endtask

    task automatic run_frame(input logic [15:0] v);
        keys = v;
        model_frame(v);
        repeat (FRAME) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vecs++; if (cols !== 4'b1110) begin errs++; $display("FAIL reset_cols: got %b want 1110", cols); end
        vecs++; if (key_code !== 4'h0) begin errs++; $display("FAIL reset_code: got %h want 0", key_code); end
        vecs++; if (key_strobe !== 1'b0) begin errs++; $display("FAIL reset_strobe: got %b want 0", key_strobe); end
        vecs++; if (key_down !== 1'b0) begin errs++; $display("FAIL reset_down: got %b want 0", key_down); end
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        int s0 = strobes;
        repeat (10) run_frame('0);
        vecs++; if (strobes != s0) begin errs++; $display("FAIL idle_strobes: got %0d want 0", strobes - s0); end
        vecs++; if (key_down !== 1'b0) begin errs++; $display("FAIL idle_down: got %b want 0", key_down); end
    endtask

    task automatic test_press();
        int s0 = strobes;
        repeat (5) run_frame(K6);
        vecs++; if (strobes - s0 != 1) begin errs++; $display("FAIL press_strobes: got %0d want 1", strobes - s0); end
        vecs++; if (key_code !== 4'h6) begin errs++; $display("FAIL press_code: got %h want 6", key_code); end
        repeat (4) run_frame('0);
        vecs++; if (key_down !== 1'b0) begin errs++; $display("FAIL press_release: got %b want 0", key_down); end
    endtask

    task automatic test_bounce();
        int s0 = strobes;
        run_frame(K6); run_frame('0); run_frame(K6);
        repeat (3) run_frame('0);
        vecs++; if (strobes != s0) begin errs++; $display("FAIL bounce_strobes: got %0d want 0", strobes - s0); end
        vecs++; if (key_down !== 1'b0) begin errs++; $display("FAIL bounce_down: got %b want 0", key_down); end
    endtask

    task automatic test_multi();
        int s0 = strobes;
        repeat (3) run_frame(K1 | K5);
        run_frame('0);
        vecs++; if (strobes != s0) begin errs++; $display("FAIL multi_strobes: got %0d want 0", strobes - s0); end
        repeat (3) run_frame(K6);
        repeat (3) run_frame(K6 | K0);
        vecs++; if (strobes - s0 != 1) begin errs++; $display("FAIL rollover_strobes: got %0d want 1", strobes - s0); end
        vecs++; if (key_code !== 4'h6) begin errs++; $display("FAIL rollover_code: got %h want 6", key_code); end
    endtask

    task automatic test_release_repress();
        run_frame('0);
        repeat (3) run_frame(K6);
        vecs++; if (key_down !== 1'b1) begin errs++; $display("FAIL repress_down: got %b want 1", key_down); end
        repeat (4) run_frame('0);
        vecs++; if (key_down !== 1'b0) begin errs++; $display("FAIL final_release: got %b want 0", key_down); end
        vecs++; if (key_code !== 4'h6) begin errs++; $display("FAIL retained_code: got %h want 6", key_code); end
    endtask

    task automatic test_reset_mid();
        int s0;
        repeat (4) run_frame(K6);
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vecs++; if (key_down !== 1'b0) begin errs++; $display("FAIL midrst_down: got %b want 0", key_down); end
        vecs++; if (key_code !== 4'h0) begin errs++; $display("FAIL midrst_code: got %h want 0", key_code); end
        vecs++; if (cols !== 4'b1110) begin errs++; $display("FAIL midrst_cols: got %b want 1110", cols); end
        vecs++; if (q.size() != 0) begin errs++; $display("FAIL midrst_sb: got %0d want 0", q.size()); end
        q.delete();
        model_reset();
        rst = 1'b0;
        s0 = strobes;
        repeat (4) run_frame(K6);
        vecs++; if (strobes - s0 != 1) begin errs++; $display("FAIL midrst_strobes: got %0d want 1", strobes - s0); end
        vecs++; if (key_code !== 4'h6) begin errs++; $display("FAIL midrst_newcode: got %h want 6", key_code); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press();
        test_bounce();
        test_multi();
        test_release_repress();
        test_reset_mid();
        @(posedge clk); #1;
        @(negedge clk); #1;
        vecs++; if (q.size() != 0) begin errs++; $display("FAIL sb_drain: got %0d want 0", q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
